pcpi_issue_unit: RTL



---
 rtl/pcpi_pkg.sv | 28 ++
 rtl/pcpi_timeout_cnt.sv | 49 ++++
 rtl/pcpi_issue_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pcpi_pkg.sv
// Shared PCPI definitions: issue FSM state encoding, default timeout,
// RV32M opcode/funct7 constants and instruction field helpers.
package pcpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WB,
    ST_DRAIN,
    ST_TRAP
  } state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Destination register field of an R-type instruction.
  function automatic logic [4:0] rd_field(input logic [31:0] insn);
    return insn[11:7];
  endfunction

  // True for an OP-class instruction carrying the M-extension funct7.
  function automatic logic is_muldiv(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/pcpi_timeout_cnt.sv
// No-responder watchdog for one PCPI request: counts REQ cycles with neither
// busy nor ready, freezes for the rest of the request once busy is seen, and
// flags expiry combinationally in the cycle the count reaches TIMEOUT_CYCLES.
module pcpi_timeout_cnt
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic idle_cyc,
  input  logic busy,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         busy_seen_q, busy_seen_d;

  // Next-state for the idle-cycle counter and the sticky busy flag.
  always_comb begin
    cnt_d       = cnt_q;
    busy_seen_d = busy_seen_q;
    if (clear) begin
      cnt_d       = '0;
      busy_seen_d = 1'b0;
    end else begin
      if (busy) busy_seen_d = 1'b1;
      if (idle_cyc && !busy_seen_q && (cnt_q != W'(TIMEOUT_CYCLES)))
        cnt_d = cnt_q + 1'b1;
    end
  end

  assign expire = idle_cyc && !busy_seen_q && (cnt_q == W'(TIMEOUT_CYCLES - 1));

  // Counter and flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      busy_seen_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      busy_seen_q <= busy_seen_d;
    end
  end

endmodule

// File: rtl/pcpi_issue_unit.sv
// PCPI initiator beside EX: registers an M-extension request, holds it stable
// while stalling the pipeline, returns the result to writeback as a one-cycle
// pulse, and drains the co-processor after a flush.
// Build option PCPI_TIMEOUT_EN adds a no-responder watchdog that raises
// trap_illegal; without it a request waits indefinitely for a response.
module pcpi_issue_unit
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        issue_valid,
  input  logic [31:0] issue_instr,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic        flush,
  output logic        stall_o,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_busy,
  input  logic        pcpi_ready,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        trap_illegal
);

  state_t      state_q, state_d;
  logic        pcpi_valid_q, pcpi_valid_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        trap_q, trap_d;
  logic        drain_q, drain_d;
  logic        stall_c;
  logic        accept;
  logic        tmo_expire;

  assign accept = (state_q == ST_IDLE) && issue_valid && !flush;

`ifdef PCPI_TIMEOUT_EN
  logic tmo_idle_cyc;
  logic tmo_busy;

  assign tmo_idle_cyc = (state_q == ST_REQ) && !pcpi_busy && !pcpi_ready;
  assign tmo_busy     = (state_q == ST_REQ) && pcpi_busy;

  pcpi_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (accept),
    .idle_cyc(tmo_idle_cyc),
    .busy    (tmo_busy),
    .expire  (tmo_expire)
  );
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_expire = 1'b0;
`endif

  // Next-state and registered-output logic; stall is the only combinational output.
  always_comb begin
    state_d      = state_q;
    pcpi_valid_d = 1'b0;
    insn_d       = insn_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    wb_valid_d   = 1'b0;
    wb_we_d      = 1'b0;
    wb_data_d    = wb_data_q;
    trap_d       = 1'b0;
    drain_d      = drain_q;
    stall_c      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall_c = issue_valid && !flush;
        if (accept) begin
          insn_d       = issue_instr;
          rs1_d        = issue_rs1;
          rs2_d        = issue_rs2;
          pcpi_valid_d = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        // Flush wins over a same-cycle ready (result dropped) and over expiry.
        if (flush) begin
          drain_d = 1'b0;
          state_d = ST_DRAIN;
        end else if (pcpi_ready) begin
          wb_valid_d = 1'b1;
          wb_we_d    = pcpi_wr && (rd_field(insn_q) != 5'd0);
          wb_data_d  = pcpi_rd;
          state_d    = ST_WB;
        end else if (tmo_expire) begin
          trap_d  = 1'b1;
          state_d = ST_TRAP;
        end else begin
          pcpi_valid_d = 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        stall_c = issue_valid;
        if (pcpi_ready) begin
          state_d = ST_IDLE;
        end else if (!pcpi_busy) begin
          if (drain_q) state_d = ST_IDLE;
          drain_d = 1'b1;
        end else begin
          drain_d = 1'b0;
        end
      end
      ST_TRAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      pcpi_valid_q <= 1'b0;
      insn_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_data_q    <= '0;
      trap_q       <= 1'b0;
      drain_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcpi_valid_q <= pcpi_valid_d;
      insn_q       <= insn_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      wb_valid_q   <= wb_valid_d;
      wb_we_q      <= wb_we_d;
      wb_data_q    <= wb_data_d;
      trap_q       <= trap_d;
      drain_q      <= drain_d;
    end
  end

  // Stall is gated by reset so every output reads zero while resetn is low.
  assign stall_o      = resetn && stall_c;
  assign pcpi_valid   = pcpi_valid_q;
  assign pcpi_insn    = insn_q;
  assign pcpi_rs1     = rs1_q;
  assign pcpi_rs2     = rs2_q;
  assign wb_valid     = wb_valid_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = rd_field(insn_q);
  assign wb_data      = wb_data_q;
  assign trap_illegal = trap_q;

endmodule
